// File: rtl/rs232_tap_pkg.sv
// rs232_tap_pkg: shared word/depth defaults for the RS-232 tap producer, status FIFO and USB drain
package rs232_tap_pkg;
  localparam int RS_DATA_W = 72;
  localparam int RS_DEPTH  = 256;
  localparam int RS_ADDR_W = 8;
endpackage

// File: rtl/mf_rs232_status_ram.sv
// mf_rs232_status_ram: simple dual-port storage, one write port, one registered read port, no reset
//   clock              : rising-edge clock
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr      : read request; rd_data loads on rd_en and holds otherwise
module mf_rs232_status_ram import rs232_tap_pkg::*; #(
  parameter int DATA_W = RS_DATA_W,
  parameter int DEPTH  = RS_DEPTH,
  parameter int ADDR_W = RS_ADDR_W
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/mf_rs232_status.sv
// mf_rs232_status: normal-mode synchronous FIFO for RS-232 line-status words
//   clock, reset_n (async, active-low), sclr (sync flush)
//   wrreq/data : write side, dropped when full
//   rdreq/q    : read side, q loads the oldest word one cycle after an accepted read
//   full, empty, usedw : registered occupancy (usedw = count mod DEPTH)
module mf_rs232_status import rs232_tap_pkg::*; #(
  parameter int DATA_W = RS_DATA_W,
  parameter int DEPTH  = RS_DEPTH,
  parameter int ADDR_W = RS_ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              sclr,
  input  logic              wrreq,
  input  logic [DATA_W-1:0] data,
  input  logic              rdreq,
  output logic [DATA_W-1:0] q,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] usedw
);
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count, count_nxt;
  logic              q_valid;
  logic [DATA_W-1:0] ram_q;
  logic              wr_ok, rd_ok;
  assign wr_ok     = wrreq & ~full;
  assign rd_ok     = rdreq & ~empty;
  assign count_nxt = count + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(rd_ok);
  assign usedw     = count[ADDR_W-1:0];
  // The RAM read register cannot be reset, so q is forced to zero until the
  // first read after reset/flush; after that it follows the held read register.
  assign q = q_valid ? ram_q : '0;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      q_valid <= 1'b0;
    end else if (sclr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      q_valid <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr + ADDR_W'(wr_ok);
      rd_ptr  <= rd_ptr + ADDR_W'(rd_ok);
      count   <= count_nxt;
      full    <= count_nxt == (ADDR_W+1)'(DEPTH);
      empty   <= count_nxt == '0;
      q_valid <= q_valid | rd_ok;
    end
  end
  mf_rs232_status_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clock   (clock),
    .wr_en   (wr_ok & ~sclr),
    .wr_addr (wr_ptr),
    .wr_data (data),
    .rd_en   (rd_ok & ~sclr),
    .rd_addr (rd_ptr),
    .rd_data (ram_q)
  );
endmodule

// File: tb/tb_mf_rs232_status.sv
// tb_mf_rs232_status: queue-model checked bench with directed scenarios and random traffic
module tb_mf_rs232_status;
  localparam int DW = 72;
  localparam int DEPTH = 256;
  logic          clock = 1'b0;
  logic          reset_n, sclr, wrreq, rdreq;
  logic [DW-1:0] data, q;
  logic          full, empty;
  logic [7:0]    usedw;
  int            checks = 0, failures = 0;
  bit            cmp_en = 0;
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_q = '0;

  mf_rs232_status dut (
    .clock(clock), .reset_n(reset_n), .sclr(sclr), .wrreq(wrreq), .data(data),
    .rdreq(rdreq), .q(q), .full(full), .empty(empty), .usedw(usedw)
  );

  always #5 clock = ~clock;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_q = '0;
    end else if (sclr) begin
      mq.delete();
      m_q = '0;
    end else begin
      automatic bit r = rdreq && mq.size() > 0;
      automatic bit w = wrreq && mq.size() < DEPTH;
      if (r) m_q = mq.pop_front();
      if (w) mq.push_back(data);
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) if (cmp_en) begin
    chk("model_q", q, m_q);
    chk("model_usedw", DW'(usedw), DW'(mq.size() % DEPTH));
    chk("model_full", DW'(full), DW'(mq.size() == DEPTH));
    chk("model_empty", DW'(empty), DW'(mq.size() == 0));
  end

  task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit s = 0);
    wrreq = w; data = d; rdreq = r; sclr = s;
    @(posedge clock);
    #2;
  endtask

  initial begin
    automatic logic [DW-1:0] exp_word;
    reset_n = 1'b0; sclr = 0; wrreq = 0; rdreq = 0; data = '0;
    repeat (2) @(posedge clock);
    #2;
    chk("reset_empty", DW'(empty), 1);
    chk("reset_full", DW'(full), 0);
    chk("reset_usedw", DW'(usedw), 0);
    chk("reset_q", q, 0);
    reset_n = 1'b1;
    cmp_en = 1;
    // single word round trip
    step(1, 72'h00_00000001_12345678, 0);
    step(0, 0, 1);
    chk("single_q", q, 72'h00_00000001_12345678);
    chk("single_empty", DW'(empty), 1);
    // fill to DEPTH, overflow, drain
    for (int i = 0; i < DEPTH; i++) step(1, DW'(i), 0);
    chk("fill_full", DW'(full), 1);
    chk("fill_usedw", DW'(usedw), 0);
    step(1, 72'h999, 0);
    chk("ovf_full", DW'(full), 1);
    chk("ovf_usedw", DW'(usedw), 0);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 1);
      chk("drain_q", q, DW'(i));
    end
    chk("drain_empty", DW'(empty), 1);
    // read on empty holds q
    step(1, 72'hAA, 0);
    step(0, 0, 1);
    chk("aa_q", q, 72'hAA);
    repeat (3) step(0, 0, 1);
    chk("underflow_q", q, 72'hAA);
    chk("underflow_usedw", DW'(usedw), 0);
    chk("underflow_empty", DW'(empty), 1);
    // simultaneous wr+rd with 5 stored, pointers wrap
    for (int i = 0; i < 5; i++) step(1, DW'(1000 + i), 0);
    exp_word = DW'(1000);
    for (int i = 0; i < 600; i++) begin
      step(1, DW'(1005 + i), 1);
      chk("stream_q", q, exp_word);
      chk("stream_usedw", DW'(usedw), 5);
      exp_word++;
    end
    repeat (5) step(0, 0, 1);
    chk("stream_tail_q", q, DW'(1604));
    chk("stream_tail_empty", DW'(empty), 1);
    // sclr beats a concurrent write
    for (int i = 0; i < 10; i++) step(1, DW'(2000 + i), 0);
    step(1, 72'h77, 0, 1);
    chk("sclr_usedw", DW'(usedw), 0);
    chk("sclr_empty", DW'(empty), 1);
    chk("sclr_q", q, 0);
    step(0, 0, 0);
    chk("sclr_wr_dropped", DW'(usedw), 0);
    // async reset mid-burst
    for (int i = 0; i < 4; i++) step(1, DW'(3000 + i), i > 1);
    wrreq = 1; data = 72'h3100;
    #1 reset_n = 1'b0;
    #1;
    chk("areset_empty", DW'(empty), 1);
    chk("areset_full", DW'(full), 0);
    chk("areset_usedw", DW'(usedw), 0);
    chk("areset_q", q, 0);
    step(1, 72'h3101, 1);
    reset_n = 1'b1;
    step(1, 72'h4000, 0);
    step(1, 72'h4001, 0);
    step(0, 0, 1);
    chk("refill_q", q, 72'h4000);
    chk("refill_usedw", DW'(usedw), 1);
    // randomized traffic with drifting write bias to visit full and empty
    for (int p = 0; p < 8; p++) begin
      automatic int wp = (p % 2) ? 30 : 80;
      for (int i = 0; i < 500; i++)
        step($urandom_range(99) < wp, {$urandom, $urandom, $urandom},
             $urandom_range(99) < 55, $urandom_range(299) == 0);
    end
    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
